channel: RTL and testbench
==========================

CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter HS_PROTOCOL, default P4PhaseBD: handshake type; P4PhaseBD = 4-phase bundled data, P2PhaseBD = 2-phase (transition) bundled data.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port s_req, input, 1: sender request.
REQ-006 Port s_data, input, WIDTH: sender data; stable while the request is pending.
REQ-007 Port s_ack, output, 1: sender acknowledge.
REQ-008 Port r_req, output, 1: receiver request; a token is offered.
REQ-009 Port r_data, output, WIDTH: held token value.
REQ-010 Port r_ack, input, 1: receiver acknowledge.
REQ-011 Port status, output, 2: IDLE=0, SEND_PEND=1, RECV_PEND=2, BOTH_PEND=3.

Function
REQ-012 Single-slot buffer: at most one token held; a token is delivered exactly once, in order.
REQ-013 4-phase send: if the slot is empty, s_ack=0 and s_req=1 at edge k, then s_data is captured, the slot is full, and s_ack=1 after edge k.
REQ-014 4-phase send: s_ack stays 1 until s_req is sampled 0, then drops after that edge.
REQ-015 4-phase receive: r_req=1 and r_data valid after the capture edge k, giving a latency of 1 cycle.
REQ-016 4-phase receive: r_ack sampled 1 causes r_req=0 next cycle.
REQ-017 4-phase receive: r_ack sampled 0 while r_req=0 (after the ack) empties the slot.
REQ-018 2-phase: an event is s_req != s_ack (sender) or r_req != r_ack (receiver).
REQ-019 2-phase send: capture toggles s_ack.
REQ-020 2-phase receive: the offer toggles r_req; r_ack == r_req empties the slot.
REQ-021 Slot full and new sender request: s_ack is withheld and the data is not captured until the slot empties.
REQ-022 Slot empties at edge k and a sender request is pending with s_ack at its idle level: capture occurs at the same edge k, giving full throughput.
REQ-023 r_data holds its last value after delivery and changes only on capture.
REQ-024 status is combinational: bit0 = sender request pending and not yet acknowledged; bit1 = slot full.
REQ-025 A receiver acknowledge without an outstanding r_req is ignored, and the protocol FSMs are unchanged.

Reset
REQ-026 rst_n low asynchronously forces s_ack=0, r_req=0, r_data=0, slot empty and status=IDLE.
REQ-027 Reset asserted mid-transfer discards the held token.
REQ-028 After release, the first rising edge samples the inputs normally.

Configuration
REQ-029 Macro CHANNEL_TOKEN_CNT_EN defined: add output token_cnt, 16 bits, reset to 0, which increments by 1 on each slot emptying (delivered token) and wraps 0xFFFF to 0.
REQ-030 Macro CHANNEL_TOKEN_CNT_EN undefined: token_cnt and its logic are absent, with no other behaviour change.

Structure
REQ-031 Package channel_pkg holds the hs_protocol_e enum (P4PhaseBD, P2PhaseBD), the chan_status_e enum (IDLE, SEND_PEND, RECV_PEND, BOTH_PEND) and the counter width constant.
REQ-032 One sub-module channel_rx_fsm implements the receiver-side offer/acknowledge FSM for both protocols.
REQ-033 The sender-side capture logic and the slot flag live in channel.

Verification
REQ-034 4-phase, WIDTH=8: s_data=0xA5 with s_req up -> s_ack=1, r_req=1 and r_data=0xA5 one cycle later; then r_ack up/down -> status returns to IDLE.
REQ-035 Back-pressure: token 0x11 held with r_ack held 0, second s_req with 0x22 -> s_ack stays 0 and status=BOTH_PEND; receiver completes -> 0x22 captured at the emptying edge.
REQ-036 Reset: rst_n pulsed low while r_req=1 -> r_req=0, s_ack=0, r_data=0x00 immediately, without waiting for clk.
REQ-037 2-phase, WIDTH=11: s_req toggled with 0x7FF -> s_ack toggles and r_req toggles; r_ack toggle -> slot empty, 4 tokens in sequence (0x001, 0x002, 0x400, 0x7FF) delivered in order.
REQ-038 CHANNEL_TOKEN_CNT_EN: 65537 tokens delivered -> token_cnt=1 (wrap).
REQ-039 Spurious r_ack=1 with the slot empty -> no state change, status stays IDLE.

Source files
------------

// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
// Shared types and constants for the single-slot handshake channel.
//   hs_protocol_e : handshake flavour (4-phase or 2-phase bundled data)
//   chan_status_e : encoding of the channel status output
//   rx_state_e    : receiver-side offer/acknowledge FSM states
//   TOKEN_CNT_W   : width of the optional delivered-token counter
// -----------------------------------------------------------------------------
package channel_pkg;

  typedef enum logic {
    P4PhaseBD = 1'b0,
    P2PhaseBD = 1'b1
  } hs_protocol_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_PEND = 2'd1,
    RECV_PEND = 2'd2,
    BOTH_PEND = 2'd3
  } chan_status_e;

  typedef enum logic [1:0] {
    RX_EMPTY    = 2'd0,
    RX_OFFER    = 2'd1,
    RX_WAIT_REL = 2'd2
  } rx_state_e;

  localparam int unsigned TOKEN_CNT_W = 16;

  // bit0 = sender request outstanding, bit1 = slot holds a token
  function automatic chan_status_e pack_status(input logic send_pend,
                                               input logic slot_full);
    return chan_status_e'({slot_full, send_pend});
  endfunction

endpackage

// File: rtl/channel_rx_fsm.sv
// -----------------------------------------------------------------------------
// channel_rx_fsm
// Receiver-side offer/acknowledge FSM of the channel, for both handshake
// flavours. The channel pulses 'load' on the edge a token is captured; this
// block offers it on r_req and flags 'slot_free' (combinational) during the
// cycle whose closing edge empties the slot.
//
// state       | meaning
// ------------+----------------------------------------------------------------
// RX_EMPTY    | no token held, receiver acknowledges are ignored
// RX_OFFER    | token offered, waiting for the receiver acknowledge event
// RX_WAIT_REL | 4-phase only: r_req dropped, waiting for r_ack to return to 0
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : token captured at this edge
//   r_ack      : receiver acknowledge
//   r_req      : receiver request (level in 4-phase, toggle in 2-phase)
//   slot_free  : slot empties at the coming edge
// -----------------------------------------------------------------------------
module channel_rx_fsm
  import channel_pkg::*;
#(
  parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic r_ack,
  output logic r_req,
  output logic slot_free
);

  rx_state_e state_q, state_d;
  logic      r_tgl_q, r_tgl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_EMPTY;
      r_tgl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_tgl_q <= r_tgl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_tgl_d   = r_tgl_q;
    slot_free = 1'b0;
    if (HS_PROTOCOL == P2PhaseBD) begin
      case (state_q)
        RX_EMPTY: begin
          if (load) begin
            state_d = RX_OFFER;
            r_tgl_d = ~r_tgl_q;
          end
        end
        RX_OFFER: begin
          // The receiver has matched our transition: token consumed.
          if (r_ack == r_tgl_q) begin
            slot_free = 1'b1;
            if (load) begin
              r_tgl_d = ~r_tgl_q;
            end else begin
              state_d = RX_EMPTY;
            end
          end
        end
        default: state_d = RX_EMPTY;
      endcase
    end else begin
      case (state_q)
        RX_EMPTY: begin
          if (load) begin
            state_d = RX_OFFER;
          end
        end
        RX_OFFER: begin
          if (r_ack) begin
            state_d = RX_WAIT_REL;
          end
        end
        RX_WAIT_REL: begin
          if (!r_ack) begin
            slot_free = 1'b1;
            // A waiting sender may refill the slot on the same edge.
            state_d   = load ? RX_OFFER : RX_EMPTY;
          end
        end
        default: state_d = RX_EMPTY;
      endcase
    end
  end

  assign r_req = (HS_PROTOCOL == P2PhaseBD) ? r_tgl_q : (state_q == RX_OFFER);

endmodule

// File: rtl/channel.sv
// -----------------------------------------------------------------------------
// channel
// Single-slot bundled-data handshake channel between a sender and a receiver.
// Holds at most one token; every token is delivered exactly once, in order.
// Sender-side capture logic and the slot flag live here; the receiver-side
// offer/acknowledge sequencing is in channel_rx_fsm.
//
// Parameters:
//   WIDTH       : data width, 1..64
//   HS_PROTOCOL : P4PhaseBD (level handshake) or P2PhaseBD (transition)
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   s_req/s_ack : sender handshake, s_data sender data
//   r_req/r_ack : receiver handshake, r_data held token value
//   status      : {slot full, sender request pending}
//   token_cnt   : delivered-token counter, wraps at 16 bits; present only
//                 when the macro CHANNEL_TOKEN_CNT_EN is defined
// -----------------------------------------------------------------------------
module channel
  import channel_pkg::*;
#(
  parameter int unsigned  WIDTH       = 8,
  parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_req,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   s_ack,
  output logic                   r_req,
  output logic [WIDTH-1:0]       r_data,
  input  logic                   r_ack,
  output logic [1:0]             status
`ifdef CHANNEL_TOKEN_CNT_EN
  ,
  output logic [TOKEN_CNT_W-1:0] token_cnt
`endif
);

  logic             s_ack_q, s_ack_d;
  logic             slot_full_q, slot_full_d;
  logic [WIDTH-1:0] r_data_q;
  logic             s_pend;
  logic             capture;
  logic             slot_free;

  // A sender request is outstanding when s_ack sits at its idle level
  // relative to s_req.
  assign s_pend = (HS_PROTOCOL == P2PhaseBD) ? (s_req ^ s_ack_q)
                                             : (s_req & ~s_ack_q);

  // Capture into an empty slot, or into the slot that empties at this very
  // edge so back-to-back tokens flow at one per handshake.
  assign capture = s_pend & (~slot_full_q | slot_free);

  always_comb begin
    s_ack_d = s_ack_q;
    if (HS_PROTOCOL == P2PhaseBD) begin
      if (capture) begin
        s_ack_d = ~s_ack_q;
      end
    end else begin
      if (capture) begin
        s_ack_d = 1'b1;
      end else if (s_ack_q && !s_req) begin
        s_ack_d = 1'b0;
      end
    end
  end

  always_comb begin
    slot_full_d = slot_full_q;
    if (capture) begin
      slot_full_d = 1'b1;
    end else if (slot_free) begin
      slot_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_q     <= 1'b0;
      slot_full_q <= 1'b0;
      r_data_q    <= '0;
    end else begin
      s_ack_q     <= s_ack_d;
      slot_full_q <= slot_full_d;
      if (capture) begin
        r_data_q <= s_data;
      end
    end
  end

  channel_rx_fsm #(
    .HS_PROTOCOL (HS_PROTOCOL)
  ) u_rx_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .r_ack     (r_ack),
    .r_req     (r_req),
    .slot_free (slot_free)
  );

`ifdef CHANNEL_TOKEN_CNT_EN
  logic [TOKEN_CNT_W-1:0] token_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_cnt_q <= '0;
    end else if (slot_free) begin
      token_cnt_q <= token_cnt_q + TOKEN_CNT_W'(1);
    end
  end

  assign token_cnt = token_cnt_q;
`endif

  assign s_ack  = s_ack_q;
  assign r_data = r_data_q;
  assign status = pack_status(s_pend, slot_full_q);

endmodule

// File: tb/tb_channel.sv
// -----------------------------------------------------------------------------
// tb_channel
// Directed bench for channel: a 4-phase WIDTH=8 instance and a 2-phase
// WIDTH=11 instance share clock and reset. Inputs change 1 ns after the
// rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_channel;
  import channel_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        s_req4 = 1'b0, r_ack4 = 1'b0;
  logic [7:0]  s_data4 = '0;
  logic        s_ack4, r_req4;
  logic [7:0]  r_data4;
  logic [1:0]  status4;

  logic        s_req2 = 1'b0, r_ack2 = 1'b0;
  logic [10:0] s_data2 = '0;
  logic        s_ack2, r_req2;
  logic [10:0] r_data2;
  logic [1:0]  status2;

`ifdef CHANNEL_TOKEN_CNT_EN
  logic [15:0] token_cnt4, token_cnt2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  channel #(.WIDTH(8), .HS_PROTOCOL(P4PhaseBD)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_req  (s_req4),
    .s_data (s_data4),
    .s_ack  (s_ack4),
    .r_req  (r_req4),
    .r_data (r_data4),
    .r_ack  (r_ack4),
    .status (status4)
`ifdef CHANNEL_TOKEN_CNT_EN
    ,
    .token_cnt (token_cnt4)
`endif
  );

  channel #(.WIDTH(11), .HS_PROTOCOL(P2PhaseBD)) u_dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_req  (s_req2),
    .s_data (s_data2),
    .s_ack  (s_ack2),
    .r_req  (r_req2),
    .r_data (r_data2),
    .r_ack  (r_ack2),
    .status (status2)
`ifdef CHANNEL_TOKEN_CNT_EN
    ,
    .token_cnt (token_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  logic [10:0] toks2 [4];
  logic        exp_tgl;

  initial begin
    toks2[0] = 11'h001;
    toks2[1] = 11'h002;
    toks2[2] = 11'h400;
    toks2[3] = 11'h7FF;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst s_ack4",  64'(s_ack4),  64'h0);
    check("rst r_req4",  64'(r_req4),  64'h0);
    check("rst r_data4", 64'(r_data4), 64'h0);
    check("rst status4", 64'(status4), 64'h0);
    check("rst s_ack2",  64'(s_ack2),  64'h0);
    check("rst r_req2",  64'(r_req2),  64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 4-phase single transfer
    s_data4 = 8'hA5;
    s_req4  = 1'b1;
    #1 check("4p pend status", 64'(status4), 64'h1);
    tick();
    check("4p s_ack up",   64'(s_ack4),  64'h1);
    check("4p r_req up",   64'(r_req4),  64'h1);
    check("4p r_data A5",  64'(r_data4), 64'hA5);
    check("4p full status", 64'(status4), 64'h2);
    s_req4 = 1'b0;
    tick();
    check("4p s_ack down", 64'(s_ack4), 64'h0);
    r_ack4 = 1'b1;
    tick();
    check("4p r_req down", 64'(r_req4), 64'h0);
    check("4p held status", 64'(status4), 64'h2);
    r_ack4 = 1'b0;
    tick();
    check("4p idle status", 64'(status4), 64'h0);
    check("4p r_data held", 64'(r_data4), 64'hA5);

    // spurious receiver acknowledge with empty slot
    r_ack4 = 1'b1;
    tick();
    check("spur status", 64'(status4), 64'h0);
    check("spur r_req",  64'(r_req4),  64'h0);
    r_ack4 = 1'b0;
    tick();
    check("spur status2", 64'(status4), 64'h0);

    // back-pressure
    s_data4 = 8'h11;
    s_req4  = 1'b1;
    tick();
    check("bp r_req 11",  64'(r_req4),  64'h1);
    check("bp r_data 11", 64'(r_data4), 64'h11);
    s_req4 = 1'b0;
    tick();
    s_data4 = 8'h22;
    s_req4  = 1'b1;
    tick();
    tick();
    check("bp s_ack held", 64'(s_ack4),  64'h0);
    check("bp both pend",  64'(status4), 64'h3);
    check("bp r_data 11b", 64'(r_data4), 64'h11);
    r_ack4 = 1'b1;
    tick();
    check("bp ack r_req", 64'(r_req4), 64'h0);
    check("bp ack s_ack", 64'(s_ack4), 64'h0);
    r_ack4 = 1'b0;
    tick();
    check("bp cap s_ack",  64'(s_ack4),  64'h1);
    check("bp cap r_req",  64'(r_req4),  64'h1);
    check("bp cap r_data", 64'(r_data4), 64'h22);
    check("bp cap status", 64'(status4), 64'h2);
    s_req4 = 1'b0;
    r_ack4 = 1'b1;
    tick();
    check("bp rel r_req", 64'(r_req4), 64'h0);
    r_ack4 = 1'b0;
    tick();
    check("bp idle", 64'(status4), 64'h0);

    // asynchronous reset while a token is offered
    s_data4 = 8'h5A;
    s_req4  = 1'b1;
    tick();
    check("ar r_req before", 64'(r_req4), 64'h1);
    #3 rst_n = 1'b0;
    #1;
    check("ar r_req",  64'(r_req4),  64'h0);
    check("ar s_ack",  64'(s_ack4),  64'h0);
    check("ar r_data", 64'(r_data4), 64'h0);
    s_req4 = 1'b0;
    #1 check("ar status", 64'(status4), 64'h0);
    rst_n   = 1'b1;
    s_data4 = 8'h66;
    s_req4  = 1'b1;
    tick();
    check("ar post s_ack",  64'(s_ack4),  64'h1);
    check("ar post r_data", 64'(r_data4), 64'h66);
    s_req4 = 1'b0;
    tick();
    r_ack4 = 1'b1;
    tick();
    r_ack4 = 1'b0;
    tick();
    check("ar post idle", 64'(status4), 64'h0);

    // 2-phase token sequence
    exp_tgl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data2 = toks2[i];
      s_req2  = ~s_req2;
      exp_tgl = ~exp_tgl;
      #1 check($sformatf("2p pend %0d", i), 64'(status2), 64'h1);
      tick();
      check($sformatf("2p s_ack %0d", i),  64'(s_ack2),  64'(exp_tgl));
      check($sformatf("2p r_req %0d", i),  64'(r_req2),  64'(exp_tgl));
      check($sformatf("2p r_data %0d", i), 64'(r_data2), 64'(toks2[i]));
      check($sformatf("2p full %0d", i),   64'(status2), 64'h2);
      r_ack2 = ~r_ack2;
      tick();
      check($sformatf("2p empty %0d", i),  64'(status2), 64'h0);
      check($sformatf("2p r_held %0d", i), 64'(r_data2), 64'(toks2[i]));
    end

`ifdef CHANNEL_TOKEN_CNT_EN
    // counter wrap: 65537 deliveries at one token per cycle
    rst_n  = 1'b0;
    s_req2 = 1'b0;
    r_ack2 = 1'b0;
    #1 check("cnt reset", 64'(token_cnt2), 64'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 65538; i++) begin
      s_req2 = ~s_ack2;
      r_ack2 = r_req2;
      tick();
    end
    check("cnt wrap", 64'(token_cnt2), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
